cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Arbitrates the instruction-cache miss port and the data-cache miss/writeback port onto the single shared lower-level memory port.
- Grants one requester at a time and forwards its address, attributes and write data to memory.
- Holds the grant until memory responds, then routes the block or ack back to the granted side only.
- Sits between the icache/dcache lowX ports and the memory/bus bridge. Only one transaction is outstanding at a time.

Parameters:
- XLEN, 32, address width
- BLK_SIZE, 128, cache line width in bits (data paths)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- i_req_valid_i  in  1  icache miss request (held until i_res_valid_o)
- i_req_addr_i  in  XLEN  icache miss address
- i_req_uncached_i  in  1  icache uncached attribute
- i_res_valid_o  out  1  response to icache, 1-cycle pulse
- i_res_blk_o  out  BLK_SIZE  returned line for icache
- d_req_valid_i  in  1  dcache request (held until d_res_valid_o)
- d_req_rw_i  in  1  1=write(back), 0=read
- d_req_addr_i  in  XLEN  dcache address
- d_req_uncached_i  in  1  dcache uncached attribute
- d_req_wdata_i  in  BLK_SIZE  write line
- d_res_valid_o  out  1  response/ack to dcache, 1-cycle pulse
- d_res_blk_o  out  BLK_SIZE  returned line for dcache
- mem_req_valid_o  out  1  request to memory
- mem_req_ready_i  in  1  memory accepts request
- mem_req_rw_o  out  1  forwarded rw (0 for icache)
- mem_req_addr_o  out  XLEN  forwarded address
- mem_req_uncached_o  out  1  forwarded attribute
- mem_req_wdata_o  out  BLK_SIZE  forwarded write data (0 for icache)
- mem_res_valid_i  in  1  memory response/ack
- mem_res_blk_i  in  BLK_SIZE  memory read line

Behaviour:
- Reset values: all *_valid_o = 0; all data/addr outputs = 0; state = IDLE; last_grant = D (so icache wins the first tie).
- Clock/reset: one clock clk_i; reset rst_i is synchronous and active-high.
- State machine: IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE:
  - If no valid request, stay in IDLE.
  - If exactly one of i/d valid, grant it.
  - If both valid, grant the side that is NOT last_grant (round-robin).
  - On grant: latch owner, addr, rw, uncached and wdata into registers; update last_grant; go to ISSUE next cycle.
- ISSUE:
  - mem_req_valid_o = 1 with the latched fields.
  - Fields are stable while valid and not ready.
  - On mem_req_valid_o && mem_req_ready_i, go to WAIT; mem_req_valid_o drops the next cycle.
- WAIT:
  - On mem_res_valid_i, drive owner's *_res_valid_o = 1 for exactly that cycle.
  - *_res_blk_o = mem_res_blk_i combinationally in that cycle (zero-latency pass-through).
  - Return to IDLE.
  - mem_res_valid_i in IDLE or ISSUE is ignored.
- Latency: request seen in IDLE at cycle N -> mem_req_valid_o at N+1. Response returns in the same cycle as mem_res_valid_i. Minimum back-to-back spacing is 3 cycles per transaction (IDLE, ISSUE, WAIT).
- Non-owner: res_valid_o is never asserted; its res_blk_o = 0.
- Icache transactions: mem_req_rw_o = 0 and mem_req_wdata_o = 0.
- Requester drops valid before grant: no transaction is issued.
- Requester drops valid after grant: the transaction still completes; the response pulse is still issued and may be ignored.
- Requester re-asserts valid in the cycle after its response: it is treated as a new request in IDLE, subject to round-robin.
- mem_req_ready_i and mem_res_valid_i both high in the same ISSUE cycle: only the accept is taken. The response must arrive in WAIT; a same-cycle response is not a legal memory behaviour.
- Reset mid-transaction: the FSM returns to IDLE immediately and any in-flight response is dropped. Memory is reset by the same rst_i.
- No combinational path exists from *_req_valid_i to mem_req_valid_o.

Optional Feature:
- Macro: ARB_DCACHE_PRIORITY_EN.
- Defined: fixed priority; the dcache always wins when both are valid in IDLE; last_grant is unused.
- Undefined: round-robin as described above.

Test Plan:
- Single icache miss, addr=0x8000_0040, memory ready immediately, response 3 cycles later with blk=0xA5..A5 -> mem_req_valid_o high for 1 cycle with rw=0, wdata=0; i_res_valid_o pulses once with blk=0xA5..A5; d_res_valid_o stays 0.
- i and d valid together from reset, d read 0x100, i read 0x200 -> icache served first, then dcache. Round-robin holds over 4 consecutive contentions: I,D,I,D. With ARB_DCACHE_PRIORITY_EN: D,D,D,D while d stays valid.
- Dcache write addr=0x40, wdata=0x1234, mem_req_ready_i held low 5 cycles -> mem_req_addr_o, mem_req_rw_o and mem_req_wdata_o stable all 6 cycles; single accept; d_res_valid_o pulses on ack.
- Spurious mem_res_valid_i in IDLE, then in ISSUE -> no res_valid_o pulses; state unchanged.
- rst_i asserted in WAIT, then mem_res_valid_i -> no response pulse; all outputs 0; next request issued normally.
- icache drops i_req_valid_i one cycle after grant -> memory request still issued; i_res_valid_o still pulses on response; next grant proceeds normally.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Shares one lower-level memory port between the icache miss port and the dcache miss/writeback port.
// Optional build macro ARB_DCACHE_PRIORITY_EN: dcache wins every tie instead of round-robin.
module cache_mem_arbiter #(
  parameter int XLEN     = 32,
  parameter int BLK_SIZE = 128
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                i_req_valid_i,
  input  logic [XLEN-1:0]     i_req_addr_i,
  input  logic                i_req_uncached_i,
  output logic                i_res_valid_o,
  output logic [BLK_SIZE-1:0] i_res_blk_o,
  input  logic                d_req_valid_i,
  input  logic                d_req_rw_i,
  input  logic [XLEN-1:0]     d_req_addr_i,
  input  logic                d_req_uncached_i,
  input  logic [BLK_SIZE-1:0] d_req_wdata_i,
  output logic                d_res_valid_o,
  output logic [BLK_SIZE-1:0] d_res_blk_o,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic                mem_req_rw_o,
  output logic [XLEN-1:0]     mem_req_addr_o,
  output logic                mem_req_uncached_o,
  output logic [BLK_SIZE-1:0] mem_req_wdata_o,
  input  logic                mem_res_valid_i,
  input  logic [BLK_SIZE-1:0] mem_res_blk_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  state_t state;
  logic   owner;
  logic   grant_i;
  logic   grant_d;
  logic   res_fire;

`ifdef ARB_DCACHE_PRIORITY_EN
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (d_req_valid_i)
      grant_d = 1'b1;
    else if (i_req_valid_i)
      grant_i = 1'b1;
  end
`else
  logic last_grant;

  // On a tie the side that did not win last time gets the port.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (i_req_valid_i && d_req_valid_i) begin
      if (last_grant == OWNER_D)
        grant_i = 1'b1;
      else
        grant_d = 1'b1;
    end else if (i_req_valid_i) begin
      grant_i = 1'b1;
    end else if (d_req_valid_i) begin
      grant_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      last_grant <= OWNER_D;
    else if (state == IDLE && grant_i)
      last_grant <= OWNER_I;
    else if (state == IDLE && grant_d)
      last_grant <= OWNER_D;
  end
`endif

  // Request fields are captured at grant so they stay stable while memory stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state              <= IDLE;
      owner              <= OWNER_I;
      mem_req_valid_o    <= 1'b0;
      mem_req_rw_o       <= 1'b0;
      mem_req_addr_o     <= '0;
      mem_req_uncached_o <= 1'b0;
      mem_req_wdata_o    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i) begin
            owner              <= OWNER_I;
            mem_req_valid_o    <= 1'b1;
            mem_req_rw_o       <= 1'b0;
            mem_req_addr_o     <= i_req_addr_i;
            mem_req_uncached_o <= i_req_uncached_i;
            mem_req_wdata_o    <= '0;
            state              <= ISSUE;
          end else if (grant_d) begin
            owner              <= OWNER_D;
            mem_req_valid_o    <= 1'b1;
            mem_req_rw_o       <= d_req_rw_i;
            mem_req_addr_o     <= d_req_addr_i;
            mem_req_uncached_o <= d_req_uncached_i;
            mem_req_wdata_o    <= d_req_wdata_i;
            state              <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
            state           <= WAIT;
          end
        end
        WAIT: begin
          if (mem_res_valid_i)
            state <= IDLE;
        end
        default: begin
          mem_req_valid_o <= 1'b0;
          state           <= IDLE;
        end
      endcase
    end
  end

  // Responses pass straight through; a reset in the same cycle swallows them.
  assign res_fire      = (state == WAIT) && mem_res_valid_i && !rst_i;
  assign i_res_valid_o = res_fire && (owner == OWNER_I);
  assign d_res_valid_o = res_fire && (owner == OWNER_D);
  assign i_res_blk_o   = i_res_valid_o ? mem_res_blk_i : '0;
  assign d_res_blk_o   = d_res_valid_o ? mem_res_blk_i : '0;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter; honours ARB_DCACHE_PRIORITY_EN for tie expectations.
module tb_cache_mem_arbiter;

  localparam int XLEN     = 32;
  localparam int BLK_SIZE = 128;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                i_req_valid_i;
  logic [XLEN-1:0]     i_req_addr_i;
  logic                i_req_uncached_i;
  logic                i_res_valid_o;
  logic [BLK_SIZE-1:0] i_res_blk_o;
  logic                d_req_valid_i;
  logic                d_req_rw_i;
  logic [XLEN-1:0]     d_req_addr_i;
  logic                d_req_uncached_i;
  logic [BLK_SIZE-1:0] d_req_wdata_i;
  logic                d_res_valid_o;
  logic [BLK_SIZE-1:0] d_res_blk_o;
  logic                mem_req_valid_o;
  logic                mem_req_ready_i;
  logic                mem_req_rw_o;
  logic [XLEN-1:0]     mem_req_addr_o;
  logic                mem_req_uncached_o;
  logic [BLK_SIZE-1:0] mem_req_wdata_o;
  logic                mem_res_valid_i;
  logic [BLK_SIZE-1:0] mem_res_blk_i;

  int assertCount = 0;
  int failCount   = 0;

  cache_mem_arbiter #(.XLEN(XLEN), .BLK_SIZE(BLK_SIZE)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_req_valid_i(i_req_valid_i), .i_req_addr_i(i_req_addr_i), .i_req_uncached_i(i_req_uncached_i),
    .i_res_valid_o(i_res_valid_o), .i_res_blk_o(i_res_blk_o),
    .d_req_valid_i(d_req_valid_i), .d_req_rw_i(d_req_rw_i), .d_req_addr_i(d_req_addr_i),
    .d_req_uncached_i(d_req_uncached_i), .d_req_wdata_i(d_req_wdata_i),
    .d_res_valid_o(d_res_valid_o), .d_res_blk_o(d_res_blk_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_req_rw_o(mem_req_rw_o),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_uncached_o(mem_req_uncached_o),
    .mem_req_wdata_o(mem_req_wdata_o), .mem_res_valid_i(mem_res_valid_i), .mem_res_blk_i(mem_res_blk_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [BLK_SIZE-1:0] observed,
                             input logic [BLK_SIZE-1:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyReset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    checkOutput("rst_mem_valid", mem_req_valid_o, 0);
    checkOutput("rst_mem_addr", mem_req_addr_o, 0);
    checkOutput("rst_mem_wdata", mem_req_wdata_o, 0);
    checkOutput("rst_res_valid", {i_res_valid_o, d_res_valid_o}, 0);
  endtask

  // Drives memory through one transaction; drop_mask {d,i} clears requesters in the response cycle.
  task automatic applyStimulus(input string tag, input logic exp_d, input logic [XLEN-1:0] exp_addr,
                               input logic exp_rw, input logic exp_unc, input logic [BLK_SIZE-1:0] exp_wdata,
                               input int ready_delay, input int resp_delay,
                               input logic [BLK_SIZE-1:0] resp_blk, input logic [1:0] drop_mask);
    for (int k = 0; k < 8 && !mem_req_valid_o; k++) tick();
    checkOutput({tag, "_req_valid"}, mem_req_valid_o, 1);
    if (mem_req_valid_o) begin
      for (int c = 0; c <= ready_delay; c++) begin
        checkOutput({tag, "_valid_hold"}, mem_req_valid_o, 1);
        checkOutput({tag, "_addr"}, mem_req_addr_o, exp_addr);
        checkOutput({tag, "_rw"}, mem_req_rw_o, exp_rw);
        checkOutput({tag, "_unc"}, mem_req_uncached_o, exp_unc);
        checkOutput({tag, "_wdata"}, mem_req_wdata_o, exp_wdata);
        if (c < ready_delay) tick();
      end
      mem_req_ready_i = 1'b1;
      tick();
      mem_req_ready_i = 1'b0;
      checkOutput({tag, "_valid_drop"}, mem_req_valid_o, 0);
      for (int w = 0; w < resp_delay; w++) begin
        checkOutput({tag, "_early_res"}, {i_res_valid_o, d_res_valid_o}, 0);
        tick();
      end
      mem_res_valid_i = 1'b1;
      mem_res_blk_i   = resp_blk;
      #1;
      checkOutput({tag, "_i_res_valid"}, i_res_valid_o, !exp_d);
      checkOutput({tag, "_d_res_valid"}, d_res_valid_o, exp_d);
      checkOutput({tag, "_i_res_blk"}, i_res_blk_o, exp_d ? '0 : resp_blk);
      checkOutput({tag, "_d_res_blk"}, d_res_blk_o, exp_d ? resp_blk : '0);
      if (drop_mask[0]) i_req_valid_i = 1'b0;
      if (drop_mask[1]) d_req_valid_i = 1'b0;
      tick();
      mem_res_valid_i = 1'b0;
      mem_res_blk_i   = '0;
      #1;
      checkOutput({tag, "_res_pulse_end"}, {i_res_valid_o, d_res_valid_o}, 0);
    end
  endtask

  logic exp_seq [4];
  logic [XLEN-1:0] seq_addr;

  initial begin
    rst_i = 1'b1; i_req_valid_i = 0; i_req_addr_i = '0; i_req_uncached_i = 0;
    d_req_valid_i = 0; d_req_rw_i = 0; d_req_addr_i = '0; d_req_uncached_i = 0; d_req_wdata_i = '0;
    mem_req_ready_i = 0; mem_res_valid_i = 0; mem_res_blk_i = '0;
    tick();
    applyReset();

    // Single icache miss, immediate accept, response three cycles after issue.
    i_req_valid_i = 1'b1; i_req_addr_i = 32'h8000_0040; i_req_uncached_i = 1'b1;
    applyStimulus("imiss", 1'b0, 32'h8000_0040, 1'b0, 1'b1, '0, 0, 2, {16{8'hA5}}, 2'b01);
    i_req_uncached_i = 1'b0;

    // Contention from reset: four back-to-back ties with both sides held valid.
    applyReset();
`ifdef ARB_DCACHE_PRIORITY_EN
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1};
`else
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    i_req_valid_i = 1'b1; i_req_addr_i = 32'h200;
    d_req_valid_i = 1'b1; d_req_rw_i = 1'b0; d_req_addr_i = 32'h100; d_req_wdata_i = '0;
    for (int n = 0; n < 4; n++) begin
      seq_addr = exp_seq[n] ? 32'h100 : 32'h200;
      applyStimulus($sformatf("rr%0d", n), exp_seq[n], seq_addr, 1'b0, 1'b0, '0, 0, 0,
                    BLK_SIZE'(n + 1), (n == 3) ? 2'b11 : 2'b00);
    end

    // Dcache writeback stalled by memory for five cycles.
    d_req_valid_i = 1'b1; d_req_rw_i = 1'b1; d_req_addr_i = 32'h40; d_req_wdata_i = 128'h1234;
    applyStimulus("dwr", 1'b1, 32'h40, 1'b1, 1'b0, 128'h1234, 5, 1, '0, 2'b10);
    d_req_rw_i = 1'b0; d_req_wdata_i = '0;

    // Spurious memory responses in IDLE and in ISSUE must be ignored.
    mem_res_valid_i = 1'b1; mem_res_blk_i = {16{8'hFF}};
    #1;
    checkOutput("spur_idle_res", {i_res_valid_o, d_res_valid_o}, 0);
    tick();
    checkOutput("spur_idle_state", mem_req_valid_o, 0);
    mem_res_valid_i = 1'b0;
    i_req_valid_i = 1'b1; i_req_addr_i = 32'h400;
    tick();
    mem_res_valid_i = 1'b1;
    #1;
    checkOutput("spur_issue_res", {i_res_valid_o, d_res_valid_o}, 0);
    tick();
    mem_res_valid_i = 1'b0;
    checkOutput("spur_issue_state", mem_req_valid_o, 1);
    applyStimulus("spur_txn", 1'b0, 32'h400, 1'b0, 1'b0, '0, 0, 0, 128'h77, 2'b01);

    // Reset while waiting for memory: the response is dropped.
    d_req_valid_i = 1'b1; d_req_addr_i = 32'h300;
    tick();
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    rst_i = 1'b1; d_req_valid_i = 1'b0; mem_res_valid_i = 1'b1; mem_res_blk_i = 128'hBEEF;
    #1;
    checkOutput("rstwait_res_during", {i_res_valid_o, d_res_valid_o}, 0);
    tick();
    rst_i = 1'b0;
    #1;
    checkOutput("rstwait_res_after", {i_res_valid_o, d_res_valid_o}, 0);
    checkOutput("rstwait_mem_valid", mem_req_valid_o, 0);
    checkOutput("rstwait_mem_addr", mem_req_addr_o, 0);
    mem_res_valid_i = 1'b0; mem_res_blk_i = '0;
    i_req_valid_i = 1'b1; i_req_addr_i = 32'h500;
    applyStimulus("post_rst", 1'b0, 32'h500, 1'b0, 1'b0, '0, 1, 0, 128'h55, 2'b01);

    // Icache withdraws its request right after being granted.
    i_req_valid_i = 1'b1; i_req_addr_i = 32'h600;
    tick();
    i_req_valid_i = 1'b0;
    applyStimulus("idrop", 1'b0, 32'h600, 1'b0, 1'b0, '0, 0, 1, 128'h66, 2'b01);
    d_req_valid_i = 1'b1; d_req_rw_i = 1'b1; d_req_addr_i = 32'h700; d_req_wdata_i = 128'hCAFE;
    applyStimulus("after_idrop", 1'b1, 32'h700, 1'b1, 1'b0, 128'hCAFE, 0, 0, '0, 2'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
